// File: rtl/alu_calc_seq_if.sv
// Calculator core bus: debounced buttons and switches in,
// captured operands, mode and registered ALU result out.
interface alu_calc_seq_if #(
    parameter int WIDTH = 8
);
    logic             enter;
    logic             sign;
    logic             chain;
    logic             clear;
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       state;
    logic [2:0]       op;
    logic             signed_md;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] magnitude;
    logic             neg;
    logic             overflow;
    logic             upd;

    modport master (
        output enter, sign, chain, clear, sw_in,
        input  A, B, state, op, signed_md,
        input  result, magnitude, neg, overflow, upd
    );

    modport slave (
        input  enter, sign, chain, clear, sw_in,
        output A, B, state, op, signed_md,
        output result, magnitude, neg, overflow, upd
    );
endinterface

// File: rtl/alu_calc_seq.sv
// Sequential calculator core: operand entry FSM, op select,
// signed/unsigned mode, chaining and a registered ALU result.
module alu_calc_seq #(
    parameter int WIDTH    = 8,
    parameter int CHAIN_EN = 1
) (
    input logic           clk,
    input logic           rst_n,
    alu_calc_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } op_t;

    localparam logic CHAIN_ON = (CHAIN_EN != 0);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q;
    logic [WIDTH-1:0] res_q, mag_q;
    logic             neg_q, ovf_q;
    logic             ev_q, upd_q;

    logic [3:0]       in_now, in_q, edg;
    logic             armed;
    logic             ev_clr, ev_ent, ev_chn, ev_sgn, ev_any;

    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] r;
    logic             ovf;
    logic             neg_d;
    logic [WIDTH-1:0] mag_d;

    assign in_now = {bus.clear, bus.chain, bus.sign, bus.enter};

    // armed stays low for one cycle after reset so a held
    // button is absorbed into in_q instead of firing.
    assign edg = in_now & ~in_q & {4{armed}};

    assign ev_clr = edg[3];
    assign ev_ent = edg[0] & ~ev_clr;
    assign ev_chn = edg[2] & CHAIN_ON & ~ev_clr & ~edg[0]
                  & (state_q == S_RES);
    assign ev_sgn = edg[1];
    assign ev_any = ev_clr | ev_ent | ev_chn | ev_sgn;

    // Button history and post-reset arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q  <= '0;
            armed <= 1'b0;
        end else begin
            in_q  <= in_now;
            armed <= 1'b1;
        end
    end

    // Next state, operand capture and op stepping.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (ev_clr) begin
            state_d = S_A;
        end else begin
            unique case (state_q)
                S_A: begin
                    if (ev_ent) begin
                        a_d     = bus.sw_in;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (ev_ent) begin
                        b_d     = bus.sw_in;
                        op_d    = OP_ADD;
                        state_d = S_RES;
                    end
                end
                S_RES: begin
                    if (ev_ent) begin
                        op_d = (op_q == OP_XOR) ? OP_ADD
                             : op_t'(op_q + 3'd1);
                    end else if (ev_chn) begin
                        a_d     = res_q;
                        state_d = S_B;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    // FSM state, operands, op and mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            if (ev_sgn) begin
                sgn_q <= ~sgn_q;
            end
        end
    end

    assign sum = {1'b0, a_q} + {1'b0, b_q};
    assign dif = {1'b0, a_q} - {1'b0, b_q};

    // ALU on the registered operands; the result register
    // therefore lags any operand/op/mode change by one edge.
    always_comb begin
        r   = '0;
        ovf = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                r   = sum[WIDTH-1:0];
                ovf = sgn_q
                    ? ((a_q[WIDTH-1] == b_q[WIDTH-1])
                       & (r[WIDTH-1] != a_q[WIDTH-1]))
                    : sum[WIDTH];
            end
            OP_SUB: begin
                r   = dif[WIDTH-1:0];
                ovf = sgn_q
                    ? ((a_q[WIDTH-1] != b_q[WIDTH-1])
                       & (r[WIDTH-1] != a_q[WIDTH-1]))
                    : dif[WIDTH];
            end
            OP_AND: r = a_q & b_q;
            OP_OR:  r = a_q | b_q;
            OP_XOR: r = a_q ^ b_q;
            default: begin
                r   = '0;
                ovf = 1'b0;
            end
        endcase
    end

    assign neg_d = sgn_q & r[WIDTH-1];
    assign mag_d = neg_d ? ({WIDTH{1'b0}} - r) : r;

    // Result registers, and update strobe one edge after an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            mag_q <= '0;
            neg_q <= 1'b0;
            ovf_q <= 1'b0;
            ev_q  <= 1'b0;
            upd_q <= 1'b0;
        end else begin
            res_q <= r;
            mag_q <= mag_d;
            neg_q <= neg_d;
            ovf_q <= ovf;
            ev_q  <= ev_any;
            upd_q <= ev_q;
        end
    end

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.state     = state_q;
    assign bus.op        = op_q;
    assign bus.signed_md = sgn_q;
    assign bus.result    = res_q;
    assign bus.magnitude = mag_q;
    assign bus.neg       = neg_q;
    assign bus.overflow  = ovf_q;
    assign bus.upd       = upd_q;
endmodule

// File: tb/tb_alu_calc_seq.sv
// Directed bench for alu_calc_seq (WIDTH=8, CHAIN_EN=1).
// Hand-computed expectations checked with immediate assertions.
module tb_alu_calc_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    int   nupd;

    alu_calc_seq_if #(.WIDTH(8)) bus ();

    alu_calc_seq #(.WIDTH(8), .CHAIN_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [7:0] v);
        bus.sw_in = v;
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        tick();
    endtask

    task automatic clr();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
    endtask

    task automatic sgn();
        bus.sign = 1'b1;
        tick();
        bus.sign = 1'b0;
        tick();
    endtask

    task automatic chn();
        bus.chain = 1'b1;
        tick();
        bus.chain = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n = 1'b0;
        bus.enter = 1'b0;
        bus.sign  = 1'b0;
        bus.chain = 1'b0;
        bus.clear = 1'b0;
        bus.sw_in = '0;
        repeat (3) tick();
        chk("rst_state", bus.state, 0);
        chk("rst_A", bus.A, 0);
        chk("rst_op", bus.op, 0);
        chk("rst_res", bus.result, 0);
        chk("rst_upd", bus.upd, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        enter(8'd100);
        enter(8'd27);
        chk("add_upd", bus.upd, 1);
        chk("add_state", bus.state, 2);
        chk("add_res", bus.result, 127);
        chk("add_ovf", bus.overflow, 0);
        tick();
        chk("upd_drop", bus.upd, 0);

        clr();
        chk("clr_state", bus.state, 0);
        enter(8'd200);
        enter(8'd100);
        chk("uadd_res", bus.result, 44);
        chk("uadd_ovf", bus.overflow, 1);
        chk("uadd_neg", bus.neg, 0);
        chk("uadd_mag", bus.magnitude, 44);

        clr();
        enter(8'd5);
        enter(8'd10);
        enter(8'd0);
        chk("sub_op", bus.op, 1);
        chk("sub_res", bus.result, 251);
        chk("sub_ovf", bus.overflow, 1);
        sgn();
        chk("sub_smd", bus.signed_md, 1);
        chk("sub_neg", bus.neg, 1);
        chk("sub_mag", bus.magnitude, 5);
        chk("sub_sovf", bus.overflow, 0);

        clr();
        enter(8'd127);
        enter(8'd1);
        chk("sadd_res", bus.result, 8'h80);
        chk("sadd_ovf", bus.overflow, 1);
        chk("sadd_neg", bus.neg, 1);
        chk("sadd_mag", bus.magnitude, 128);

        sgn();
        clr();
        enter(8'd10);
        enter(8'd20);
        chk("ch_res0", bus.result, 30);
        chn();
        chk("ch_state", bus.state, 1);
        chk("ch_A", bus.A, 30);
        enter(8'd5);
        chk("ch_res1", bus.result, 35);

        clr();
        enter(8'd7);
        chk("sb_state", bus.state, 1);
        bus.sw_in = 8'd99;
        bus.clear = 1'b1;
        bus.enter = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.enter = 1'b0;
        tick();
        chk("prio_state", bus.state, 0);
        chk("prio_B", bus.B, 5);

        nupd = 0;
        bus.sw_in = 8'd42;
        bus.enter = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.upd) nupd++;
        end
        bus.enter = 1'b0;
        tick();
        chk("hold_state", bus.state, 1);
        chk("hold_A", bus.A, 42);
        chk("hold_upd", nupd, 1);

        bus.sw_in = 8'd3;
        bus.enter = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("arst_state", bus.state, 0);
        chk("arst_A", bus.A, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("norep_state", bus.state, 0);
        chk("norep_upd", bus.upd, 0);
        bus.enter = 1'b0;
        tick();
        enter(8'd9);
        chk("post_state", bus.state, 1);
        chk("post_A", bus.A, 9);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
